// File: rtl/psr_cond_unit.sv
// Processor status register with per-flag write mask and registered branch-condition evaluation.
// Optional PSR shadow stack for interrupt entry/return is compiled in with `define PSR_STACK_EN.
module psr_cond_unit #(
  parameter  int STACK_DEPTH = 4,
  localparam int PRSWIDTH    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PRSWIDTH-1:0] flags_in,
  input  logic                psr_we,
  input  logic [PRSWIDTH-1:0] psr_mask,
  input  logic                cond_req,
  input  logic [3:0]          cond_code,
  input  logic                psr_push,
  input  logic                psr_pop,
  output logic [PRSWIDTH-1:0] psr,
  output logic                cond_valid,
  output logic                cond_taken,
  output logic [4:0]          stack_depth,
  output logic                stack_err
);

  localparam int psrC = 0;
  localparam int psrL = 1;
  localparam int psrF = 2;
  localparam int psrZ = 3;
  localparam int psrN = 4;

  logic [PRSWIDTH-1:0] r_psr;
  logic                r_cond_valid;
  logic                r_cond_taken;
  logic [PRSWIDTH-1:0] w_we_psr;
  logic [PRSWIDTH-1:0] w_psr_next;
  logic                w_taken;

  function automatic logic cond_eval(input logic [3:0] code, input logic [PRSWIDTH-1:0] p);
    logic res;
    case (code)
      4'h0:    res = p[psrZ];
      4'h1:    res = ~p[psrZ];
      4'h2:    res = p[psrC];
      4'h3:    res = ~p[psrC];
      4'h4:    res = p[psrL];
      4'h5:    res = ~p[psrL];
      4'h6:    res = p[psrN];
      4'h7:    res = ~p[psrN];
      4'h8:    res = p[psrF];
      4'h9:    res = ~p[psrF];
      4'hA:    res = ~p[psrL] & ~p[psrZ];
      4'hB:    res = p[psrL] | p[psrZ];
      4'hC:    res = ~p[psrN] & ~p[psrZ];
      4'hD:    res = p[psrN] | p[psrZ];
      4'hE:    res = 1'b1;
      4'hF:    res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Masked flag update; unmasked bits hold.
  always_comb begin
    w_we_psr = r_psr;
    if (psr_we) begin
      w_we_psr = (r_psr & ~psr_mask) | (flags_in & psr_mask);
    end else begin
      w_we_psr = r_psr;
    end
  end

`ifdef PSR_STACK_EN
  localparam int DW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PRSWIDTH-1:0] r_stack [STACK_DEPTH];
  logic [4:0]          r_depth;
  logic                r_stack_err;
  logic                w_full;
  logic                w_empty;
  logic                w_push_ok;
  logic                w_pop_ok;
  logic                w_err;
  logic [DW-1:0]       w_wr_idx;
  logic [DW-1:0]       w_top_idx;

  assign w_full    = (r_depth == 5'(STACK_DEPTH));
  assign w_empty   = (r_depth == 5'd0);
  assign w_wr_idx  = r_depth[DW-1:0];
  assign w_top_idx = r_depth[DW-1:0] - DW'(1);

  // Push/pop arbitration; simultaneous push and pop is rejected as an error.
  always_comb begin
    w_push_ok = 1'b0;
    w_pop_ok  = 1'b0;
    w_err     = 1'b0;
    if (psr_push && psr_pop) begin
      w_err = 1'b1;
    end else if (psr_push) begin
      if (w_full) begin
        w_err = 1'b1;
      end else begin
        w_push_ok = 1'b1;
      end
    end else if (psr_pop) begin
      if (w_empty) begin
        w_err = 1'b1;
      end else begin
        w_pop_ok = 1'b1;
      end
    end else begin
      w_err = 1'b0;
    end
  end

  // PSR next state: a successful pop overrides the flag write.
  always_comb begin
    w_psr_next = w_we_psr;
    if (w_pop_ok) begin
      w_psr_next = r_stack[w_top_idx];
    end else begin
      w_psr_next = w_we_psr;
    end
  end

  // Stack occupancy and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth     <= 5'd0;
      r_stack_err <= 1'b0;
    end else begin
      r_stack_err <= w_err;
      if (w_push_ok) begin
        r_depth <= r_depth + 5'd1;
      end else if (w_pop_ok) begin
        r_depth <= r_depth - 5'd1;
      end else begin
        r_depth <= r_depth;
      end
    end
  end

  // Stack storage saves the pre-update PSR; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_stack[w_wr_idx] <= r_psr;
    end
  end

  assign stack_depth = r_depth;
  assign stack_err   = r_stack_err;
`else
  logic w_unused_stack;

  assign w_unused_stack = psr_push ^ psr_pop;

  // Without the stack the PSR only follows the flag write path.
  always_comb begin
    w_psr_next = w_we_psr;
  end

  assign stack_depth = 5'd0;
  assign stack_err   = 1'b0;
`endif

  // Condition is evaluated on the bypassed next-state PSR.
  always_comb begin
    w_taken = cond_eval(cond_code, w_psr_next);
  end

  // PSR and registered condition response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psr        <= 5'd0;
      r_cond_valid <= 1'b0;
      r_cond_taken <= 1'b0;
    end else begin
      r_psr        <= w_psr_next;
      r_cond_valid <= cond_req;
      if (cond_req) begin
        r_cond_taken <= w_taken;
      end else begin
        r_cond_taken <= r_cond_taken;
      end
    end
  end

  assign psr        = r_psr;
  assign cond_valid = r_cond_valid;
  assign cond_taken = r_cond_taken;

endmodule

// File: tb/tb_psr_cond_unit.sv
// Randomized and directed bench for psr_cond_unit against a behavioural model (queue-based stack).
module tb_psr_cond_unit;
  localparam int DEPTH = 4;
`ifdef PSR_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] flags_in = 5'd0;
  logic       psr_we = 1'b0;
  logic [4:0] psr_mask = 5'd0;
  logic       cond_req = 1'b0;
  logic [3:0] cond_code = 4'd0;
  logic       psr_push = 1'b0;
  logic       psr_pop = 1'b0;
  logic [4:0] psr;
  logic       cond_valid;
  logic       cond_taken;
  logic [4:0] stack_depth;
  logic       stack_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] m_psr = 5'd0;
  logic [4:0] m_stk[$];
  logic       m_valid = 1'b0;
  logic       m_taken = 1'b0;
  logic       m_err = 1'b0;

  psr_cond_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .psr_we(psr_we),
    .psr_mask(psr_mask), .cond_req(cond_req), .cond_code(cond_code),
    .psr_push(psr_push), .psr_pop(psr_pop), .psr(psr), .cond_valid(cond_valid),
    .cond_taken(cond_taken), .stack_depth(stack_depth), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Flag order in the vector: C=0 L=1 F=2 Z=3 N=4.
  function automatic logic cond_ref(input logic [3:0] code, input logic [4:0] p);
    logic c, l, f, z, n, t;
    logic [4:0] pick;
    c = p[0]; l = p[1]; f = p[2]; z = p[3]; n = p[4];
    pick = {f, n, l, c, z};
    if (code < 4'd10) return pick[code >> 1] ^ code[0];
    if (code < 4'd14) begin
      t = (code < 4'd12) ? (l | z) : (n | z);
      return code[0] ? t : ~t;
    end
    return code == 4'hE;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_psr"}, 32'(psr), 32'(m_psr));
    chk({tag, "_valid"}, 32'(cond_valid), 32'(m_valid));
    chk({tag, "_taken"}, 32'(cond_taken), 32'(m_taken));
    chk({tag, "_depth"}, 32'(stack_depth), STK ? 32'(m_stk.size()) : 32'd0);
    chk({tag, "_err"}, 32'(stack_err), 32'(m_err));
  endtask

  task automatic drive(input logic we, input logic [4:0] mask, input logic [4:0] fl,
                       input logic req, input logic [3:0] code,
                       input logic push, input logic pop, input string tag);
    logic [4:0] nxt;
    logic popped;
    psr_we = we; psr_mask = mask; flags_in = fl; cond_req = req; cond_code = code;
    psr_push = push; psr_pop = pop;
    nxt = m_psr; popped = 1'b0; m_err = 1'b0;
    if (STK) begin
      if (push && pop) m_err = 1'b1;
      else if (push) begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else m_stk.push_back(m_psr);
      end else if (pop) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else begin nxt = m_stk.pop_back(); popped = 1'b1; end
      end
    end
    if (!popped && we)
      for (int i = 0; i < 5; i++) if (mask[i]) nxt[i] = fl[i];
    m_psr = nxt;
    m_valid = req;
    if (req) m_taken = cond_ref(code, nxt);
    @(posedge clk); #1;
    check_all(tag);
    psr_we = 1'b0; psr_mask = 5'd0; flags_in = 5'd0; cond_req = 1'b0;
    cond_code = 4'd0; psr_push = 1'b0; psr_pop = 1'b0;
  endtask

  task automatic model_reset();
    m_psr = 5'd0; m_valid = 1'b0; m_taken = 1'b0; m_err = 1'b0;
    m_stk.delete();
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); rst_n = 1'b1;

    drive(1'b1, 5'h1F, 5'b11000, 1'b0, 4'h0, 1'b0, 1'b0, "wr_zn");
    chk("zn_const", 32'(psr), 32'h18);
    drive(1'b0, 5'h00, 5'h00, 1'b1, 4'h0, 1'b0, 1'b0, "eq");
    chk("eq_const", 32'(cond_taken), 32'd1);
    drive(1'b0, 5'h00, 5'h00, 1'b1, 4'h1, 1'b0, 1'b0, "ne");
    chk("ne_const", 32'(cond_taken), 32'd0);
    drive(1'b0, 5'h00, 5'h00, 1'b1, 4'hD, 1'b0, 1'b0, "ge");
    chk("ge_const", 32'(cond_taken), 32'd1);

    drive(1'b1, 5'h1F, 5'b00001, 1'b0, 4'h0, 1'b0, 1'b0, "wr_c");
    drive(1'b1, 5'b01000, 5'b01000, 1'b0, 4'h0, 1'b0, 1'b0, "mask_z");
    chk("mask_const", 32'(psr), 32'h09);

    drive(1'b1, 5'h1F, 5'h00, 1'b0, 4'h0, 1'b0, 1'b0, "clr");
    drive(1'b1, 5'h1F, 5'b01000, 1'b1, 4'h0, 1'b0, 1'b0, "bypass");
    chk("bypass_const", 32'({cond_valid, cond_taken}), 32'd3);
    drive(1'b0, 5'h00, 5'h00, 1'b0, 4'h0, 1'b0, 1'b0, "hold");

    for (int v = 0; v < 32; v++) begin
      drive(1'b1, 5'h1F, 5'(v), 1'b0, 4'h0, 1'b0, 1'b0, "sw_wr");
      for (int c = 0; c < 16; c++) drive(1'b0, 5'h00, 5'h00, 1'b1, 4'(c), 1'b0, 1'b0, "sweep");
      drive(1'b0, 5'h00, 5'h00, 1'b0, 4'h0, 1'b0, 1'b0, "sw_idle");
    end

    for (int k = 0; k < 5; k++)
      drive(1'b1, 5'h1F, 5'(3 * k + 2), 1'b0, 4'h0, 1'b1, 1'b0, "push");
    if (STK) chk("full_const", 32'({stack_err, stack_depth}), 32'h24);
    for (int k = 0; k < 5; k++)
      drive(1'b0, 5'h00, 5'h00, 1'b1, 4'hE, 1'b0, 1'b1, "pop");
    if (STK) chk("empty_const", 32'({stack_err, stack_depth}), 32'h20);
    drive(1'b1, 5'h1F, 5'h15, 1'b0, 4'h0, 1'b1, 1'b1, "pushpop");

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1), 5'($urandom), 5'($urandom), $urandom_range(0, 3) != 0,
            4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, "rand");

    while (m_stk.size() != 0) drive(1'b0, 5'h00, 5'h00, 1'b0, 4'h0, 1'b0, 1'b1, "drain");
    drive(1'b1, 5'h1F, 5'h1B, 1'b0, 4'h0, 1'b1, 1'b0, "pre_rst");
    drive(1'b1, 5'h1F, 5'h0F, 1'b1, 4'hE, 1'b1, 1'b0, "pre_rst2");
    psr_we = 1'b1; psr_mask = 5'h1F; flags_in = 5'h1F; cond_req = 1'b1; cond_code = 4'hE;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    psr_we = 1'b0; psr_mask = 5'd0; flags_in = 5'd0; cond_req = 1'b0; cond_code = 4'd0;
    @(negedge clk); rst_n = 1'b1;
    drive(1'b0, 5'h00, 5'h00, 1'b0, 4'h0, 1'b0, 1'b0, "post_rst");
    drive(1'b0, 5'h00, 5'h00, 1'b1, 4'h2, 1'b0, 1'b0, "post_req");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
